seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for N common-electrode 7-segment digits, generalising the single-digit BCD decoder.
- Latches a packed multi-digit value through a load strobe and scans one digit per refresh tick.
- Decodes BCD or hex, with per-digit decimal point, leading-zero blanking and configurable output polarity.
- Sits between the numeric datapath (counters, ALU results) and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles per digit slot; must be >= 1.
- SEG_ACTIVE_LOW, 0, 1 inverts seg_output and dp_out at the pins.
- SEL_ACTIVE_LOW, 1, 1 makes digit_sel active-low.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- load, input, 1, single-cycle strobe that captures value_in, dp_in and hex_mode.
- value_in, input, 4*N_DIGITS, packed nibbles; nibble 0 [3:0] is the rightmost (least significant) digit.
- dp_in, input, N_DIGITS, decimal point per digit.
- hex_mode, input, 1, 1 decodes 10-15 as A-F; 0 blanks 10-15.
- blank_lz, input, 1, live (unlatched) leading-zero blanking enable.
- seg_output, output, 7, segments a..g in bits 6..0; active-high segment codes match the existing decoder (0 = 1111110).
- dp_out, output, 1, decimal point for the active digit.
- digit_sel, output, N_DIGITS, one-hot enable of the active digit.
- digit_idx, output, max(1,$clog2(N_DIGITS)), index of the active digit.
- frame_start, output, 1, one-cycle pulse when digit 0 becomes active.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Prescaler, digit_idx, shadow and display registers and the pending flag all go to 0.
  - digit_sel is all-inactive; seg_output and dp_out are at the inactive level; frame_start is 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - tick is asserted when the count equals REFRESH_DIV-1. With REFRESH_DIV=1, tick occurs every cycle.
- Scan:
  - On tick, digit_idx increments and wraps N_DIGITS-1 -> 0.
  - With N_DIGITS=1, digit_idx stays 0 and every tick is a wrap.
- Load:
  - load=1 writes value_in, dp_in and hex_mode to the shadow register and sets pending.
  - A further load while pending overwrites the shadow (last write wins).
- Commit (tear-free update):
  - On a tick that wraps digit_idx to 0 while pending=1, the shadow is copied into the display register and pending clears.
  - If load coincides with a committing tick, the pre-load shadow commits. The new data enters the shadow and pending stays set for the next frame.
- Decode:
  - 0-9 use the existing codes.
  - With hex_mode=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - With hex_mode=0, values 10-15 give 0000000.
- Leading-zero blanking:
  - When blank_lz=1, digit k is blanked (segments 0000000) if all display nibbles from N_DIGITS-1 down to k are 0.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
- Output registration and timing:
  - All outputs are registered from digit_idx and the display register. They reflect a new digit_idx one cycle after the tick edge.
  - frame_start pulses in that same cycle.
  - Polarity inversion is applied in the final register.
- Reset mid-scan: all state returns to reset values and pending data is discarded.
- The first digit is shown on the second cycle after rst_n deasserts.

Decomposition:
- seg7_pkg holds:
  - the seg7_t typedef (logic [6:0]);
  - localparam codes SEG_0..SEG_9, SEG_A..SEG_F and SEG_BLANK;
  - a pure function seg7_encode(nibble, hex_mode).
- One combinational sub-module, seg7_hex_decoder (nibble, hex_mode -> seg7_t), is instantiated once on the muxed nibble.
- Prescaler, scan index, shadow/commit logic and the output registers stay in the top module.

Test Plan:
- Reset release, N_DIGITS=4, REFRESH_DIV=4 -> digit_sel one-hot rotates 0,1,2,3,0 every 4 cycles, frame_start every 16 cycles, digit_idx 0 first.
- load value_in=16'h1234 mid-frame -> display still shows 0000 until the next wrap, then the digits read 4,3,2,1 (seg 0110011,1111001,1101101,0110000) on idx 0..3.
- value 16'h00A5, hex_mode=1, blank_lz=1 -> idx0=1011011, idx1=1110111, idx2 and idx3 show 0000000; with hex_mode=0, idx1 shows 0000000.
- value 16'h0000, blank_lz=1, dp_in=4'b0100 -> idx0 shows 1111110, idx1 and idx3 show 0000000, idx2 shows 0000000 with dp_out=1.
- load coincident with a wrapping tick (shadow=1111, new=2222) -> 1111 is displayed this frame and 2222 the next.
- SEG_ACTIVE_LOW=1, SEL_ACTIVE_LOW=1, digit 8 -> seg_output=0000000, digit_sel has a single 0; assert rst_n low mid-scan -> outputs go inactive on the next edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment types, segment codes (a..g in bits 6..0, active-high) and the
// nibble-to-segment encoding used by the scan driver.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  typedef logic [SEG_W-1:0] seg7_t;

  localparam seg7_t SEG_0     = 7'b1111110;
  localparam seg7_t SEG_1     = 7'b0110000;
  localparam seg7_t SEG_2     = 7'b1101101;
  localparam seg7_t SEG_3     = 7'b1111001;
  localparam seg7_t SEG_4     = 7'b0110011;
  localparam seg7_t SEG_5     = 7'b1011011;
  localparam seg7_t SEG_6     = 7'b1011111;
  localparam seg7_t SEG_7     = 7'b1110000;
  localparam seg7_t SEG_8     = 7'b1111111;
  localparam seg7_t SEG_9     = 7'b1111011;
  localparam seg7_t SEG_A     = 7'b1110111;
  localparam seg7_t SEG_B     = 7'b0011111;
  localparam seg7_t SEG_C     = 7'b1001110;
  localparam seg7_t SEG_D     = 7'b0111101;
  localparam seg7_t SEG_E     = 7'b1001111;
  localparam seg7_t SEG_F     = 7'b1000111;
  localparam seg7_t SEG_BLANK = 7'b0000000;

  // Letters only appear in hex mode; in BCD mode 10..15 are shown blank.
  function automatic seg7_t seg7_encode(input logic [3:0] nibble, input logic hex_mode);
    seg7_t code;
    code = SEG_BLANK;
    case (nibble)
      4'h0: code = SEG_0;
      4'h1: code = SEG_1;
      4'h2: code = SEG_2;
      4'h3: code = SEG_3;
      4'h4: code = SEG_4;
      4'h5: code = SEG_5;
      4'h6: code = SEG_6;
      4'h7: code = SEG_7;
      4'h8: code = SEG_8;
      4'h9: code = SEG_9;
      4'hA: code = hex_mode ? SEG_A : SEG_BLANK;
      4'hB: code = hex_mode ? SEG_B : SEG_BLANK;
      4'hC: code = hex_mode ? SEG_C : SEG_BLANK;
      4'hD: code = hex_mode ? SEG_D : SEG_BLANK;
      4'hE: code = hex_mode ? SEG_E : SEG_BLANK;
      4'hF: code = hex_mode ? SEG_F : SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble decoder (BCD or hex) producing active-high segment codes.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output seg7_t      seg_c
);

  assign seg_c = seg7_encode(nibble, hex_mode);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: shadow/display double buffer with
// frame-aligned commit, leading-zero blanking and registered, polarity-adjusted pins.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output seg7_t                 seg_output,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   digit_sel,
  output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] digit_idx,
  output logic                  frame_start
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned VAL_W = 4 * N_DIGITS;

  // Inactive pin levels double as the XOR masks applied in the output register.
  localparam seg7_t               SEG_INV = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic                DP_INV  = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] SEL_INV = {N_DIGITS{SEL_ACTIVE_LOW}};

  logic [CNT_W-1:0]    pre_cnt;
  logic [IDX_W-1:0]    scan_idx;
  logic                tick_q;
  logic [VAL_W-1:0]    shadow_value;
  logic [N_DIGITS-1:0] shadow_dp;
  logic                shadow_hex;
  logic                pending;
  logic [VAL_W-1:0]    disp_value;
  logic [N_DIGITS-1:0] disp_dp;
  logic                disp_hex;

  logic                tick_c;
  logic                wrap_c;
  logic [3:0]          nibble_c;
  logic                dp_c;
  logic                upper_zero_c;
  logic                blank_c;
  logic [N_DIGITS-1:0] sel_c;
  seg7_t               dec_seg_c;
  seg7_t               seg_c;

  assign tick_c = (pre_cnt == CNT_W'(REFRESH_DIV - 1));
  assign wrap_c = tick_c && (scan_idx == IDX_W'(N_DIGITS - 1));

  // Refresh prescaler
  always_ff @(posedge clk) begin
    if (!rst_n)      pre_cnt <= '0;
    else if (tick_c) pre_cnt <= '0;
    else             pre_cnt <= pre_cnt + CNT_W'(1);
  end

  // Scan index; tick_q marks the cycle right after the index moved
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_idx <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= tick_c;
      if (tick_c) scan_idx <= wrap_c ? '0 : scan_idx + IDX_W'(1);
    end
  end

  // Shadow capture and frame-aligned commit; a load on the committing tick
  // lands in the shadow after the old shadow has been copied out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_hex   <= 1'b0;
      pending      <= 1'b0;
      disp_value   <= '0;
      disp_dp      <= '0;
      disp_hex     <= 1'b0;
    end else begin
      if (wrap_c && pending) begin
        disp_value <= shadow_value;
        disp_dp    <= shadow_dp;
        disp_hex   <= shadow_hex;
      end
      if (load) begin
        shadow_value <= value_in;
        shadow_dp    <= dp_in;
        shadow_hex   <= hex_mode;
        pending      <= 1'b1;
      end else if (wrap_c && pending) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    nibble_c     = 4'h0;
    dp_c         = 1'b0;
    upper_zero_c = 1'b1;
    sel_c        = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      sel_c[k] = (scan_idx == IDX_W'(k));
      if (scan_idx == IDX_W'(k)) begin
        nibble_c = disp_value[4*k +: 4];
        dp_c     = disp_dp[k];
      end
      if ((IDX_W'(k) >= scan_idx) && (disp_value[4*k +: 4] != 4'h0)) upper_zero_c = 1'b0;
    end
  end

  assign blank_c = blank_lz && upper_zero_c && (scan_idx != '0);

  seg7_hex_decoder u_dec (
    .nibble   (nibble_c),
    .hex_mode (disp_hex),
    .seg_c    (dec_seg_c)
  );

  assign seg_c = blank_c ? SEG_BLANK : dec_seg_c;

  // Pin registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_output  <= SEG_INV;
      dp_out      <= DP_INV;
      digit_sel   <= SEL_INV;
      digit_idx   <= '0;
      frame_start <= 1'b0;
    end else begin
      seg_output  <= seg_c ^ SEG_INV;
      dp_out      <= dp_c ^ DP_INV;
      digit_sel   <= sel_c ^ SEL_INV;
      digit_idx   <= scan_idx;
      frame_start <= tick_q && (scan_idx == '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle reference model, vector table, corner sequences
// and random loads, on an active-high-segment and an active-low-segment instance.
module tb_seg7_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        hex_mode = 1'b0;
  logic        blank_lz = 1'b0;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fs_a, fs_b;
  logic [3:0] sel_a, sel_b;
  logic [1:0] idx_a, idx_b;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .dp_in(dp_in),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .seg_output(seg_a), .dp_out(dp_a),
    .digit_sel(sel_a), .digit_idx(idx_a), .frame_start(fs_a));

  seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .dp_in(dp_in),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .seg_output(seg_b), .dp_out(dp_b),
    .digit_sel(sel_b), .digit_idx(idx_b), .frame_start(fs_b));

  logic [6:0] code_tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
    7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Active-high segments for digit k of a displayed value
  function automatic logic [6:0] ref_seg(logic [15:0] v, logic hex, int k, logic blz);
    logic [15:0] up;
    int nib;
    up  = v >> (4 * k);
    nib = int'(up[3:0]);
    if (blz && k != 0 && up == 16'h0) return 7'b0000000;
    if (nib >= 10 && !hex) return 7'b0000000;
    return code_tbl[nib];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame state as integers plus the expected pin values
  int         m_cnt, m_idx;
  bit         m_pend, m_tick_d, m_tick;
  logic [15:0] sh_v, d_v;
  logic [3:0]  sh_dp, d_dp;
  logic        sh_hex, d_hex;
  logic [6:0]  e_seg;
  logic        e_dp, e_fs;
  logic [3:0]  e_sel;
  logic [1:0]  e_idx;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_idx = 0; m_pend = 0; m_tick_d = 0;
      sh_v = '0; sh_dp = '0; sh_hex = 0; d_v = '0; d_dp = '0; d_hex = 0;
      e_seg = '0; e_dp = 0; e_sel = 4'hF; e_idx = '0; e_fs = 0;
    end else begin
      e_idx = 2'(m_idx);
      e_sel = ~(4'(4'b0001 << m_idx));
      e_seg = ref_seg(d_v, d_hex, m_idx, blank_lz);
      e_dp  = d_dp[m_idx];
      e_fs  = m_tick_d && (m_idx == 0);
      m_tick   = (m_cnt == DIV - 1);
      m_tick_d = m_tick;
      if (m_tick) begin
        if (m_idx == N - 1 && m_pend) begin
          d_v = sh_v; d_dp = sh_dp; d_hex = sh_hex; m_pend = 0;
        end
        m_idx = (m_idx + 1) % N;
      end
      m_cnt = (m_cnt + 1) % DIV;
      if (load) begin
        sh_v = value_in; sh_dp = dp_in; sh_hex = hex_mode; m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_a", {seg_a, dp_a, sel_a, idx_a, fs_a}, {e_seg, e_dp, e_sel, e_idx, e_fs});
      check("model_b", {seg_b, dp_b, sel_b, idx_b, fs_b}, {~e_seg, ~e_dp, e_sel, e_idx, e_fs});
    end
  end

  task automatic wait_fs(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (fs_a) ok = 1;
    end
    check(name, 32'(ok), 1);
  endtask

  task automatic wait_idx(input logic [1:0] idx);
    bit ok;
    ok = (idx_a == idx);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (idx_a == idx) ok = 1;
    end
    check("idx_timeout", 32'(ok), 1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic hex);
    value_in = v; dp_in = dp; hex_mode = hex; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  typedef struct {
    logic [15:0] v;
    logic [3:0]  dp;
    logic        hex;
    logic        blz;
    logic [1:0]  idx;
    logic [6:0]  seg;
    logic        dpo;
  } vec_t;

  vec_t vt[$];
  int   fs_cyc[$];
  logic [15:0] rv;

  initial begin
    vt.push_back('{16'h1234, 4'h0, 1'b0, 1'b0, 2'd0, 7'b0110011, 1'b0});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 1'b0, 2'd1, 7'b1111001, 1'b0});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 1'b0, 2'd2, 7'b1101101, 1'b0});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 1'b0, 2'd3, 7'b0110000, 1'b0});
    vt.push_back('{16'h00A5, 4'h0, 1'b1, 1'b1, 2'd0, 7'b1011011, 1'b0});
    vt.push_back('{16'h00A5, 4'h0, 1'b1, 1'b1, 2'd1, 7'b1110111, 1'b0});
    vt.push_back('{16'h00A5, 4'h0, 1'b1, 1'b1, 2'd2, 7'b0000000, 1'b0});
    vt.push_back('{16'h00A5, 4'h0, 1'b1, 1'b1, 2'd3, 7'b0000000, 1'b0});
    vt.push_back('{16'h00A5, 4'h0, 1'b0, 1'b1, 2'd1, 7'b0000000, 1'b0});
    vt.push_back('{16'h00A5, 4'h0, 1'b0, 1'b0, 2'd2, 7'b1111110, 1'b0});
    vt.push_back('{16'h0000, 4'h4, 1'b0, 1'b1, 2'd0, 7'b1111110, 1'b0});
    vt.push_back('{16'h0000, 4'h4, 1'b0, 1'b1, 2'd1, 7'b0000000, 1'b0});
    vt.push_back('{16'h0000, 4'h4, 1'b0, 1'b1, 2'd2, 7'b0000000, 1'b1});
    vt.push_back('{16'h0000, 4'h4, 1'b0, 1'b1, 2'd3, 7'b0000000, 1'b0});
    vt.push_back('{16'hCDEF, 4'h0, 1'b1, 1'b0, 2'd0, 7'b1000111, 1'b0});
    vt.push_back('{16'hCDEF, 4'h0, 1'b1, 1'b0, 2'd1, 7'b1001111, 1'b0});
    vt.push_back('{16'hCDEF, 4'h0, 1'b1, 1'b0, 2'd2, 7'b0111101, 1'b0});
    vt.push_back('{16'hCDEF, 4'h0, 1'b1, 1'b0, 2'd3, 7'b1001110, 1'b0});

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_seg_a", seg_a, 7'h00);
    check("rst_dp_a", dp_a, 1'b0);
    check("rst_sel_a", sel_a, 4'hF);
    check("rst_idx_a", idx_a, 2'd0);
    check("rst_fs_a", fs_a, 1'b0);
    check("rst_seg_b", seg_b, 7'h7F);
    check("rst_dp_b", dp_b, 1'b1);

    // Scan rotation after reset release
    chk_en = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("rot_idx", idx_a, 32'((c / 4) % 4));
      if (c == 0) check("first_sel", sel_a, 4'b1110);
      if (fs_a) fs_cyc.push_back(c);
    end
    check("fs_count", fs_cyc.size(), 2);
    if (fs_cyc.size() == 2) begin
      check("fs_first", fs_cyc[0], 16);
      check("fs_period", fs_cyc[1] - fs_cyc[0], 16);
    end

    // Mid-frame load stays hidden until the next frame
    do_load(16'h1234, 4'h0, 1'b0);
    for (int i = 0; i < 40 && !fs_a; i++) begin
      @(negedge clk);
      if (!fs_a) check("stale_frame", seg_a, 7'b1111110);
    end
    check("new_frame_fs", fs_a, 1'b1);
    check("new_frame_d0", seg_a, 7'b0110011);

    // Vector table
    for (int i = 0; i < vt.size(); i++) begin
      if (i == 0 || vt[i].v != vt[i-1].v || vt[i].dp != vt[i-1].dp || vt[i].hex != vt[i-1].hex) begin
        do_load(vt[i].v, vt[i].dp, vt[i].hex);
        wait_fs("vec_fs1");
        wait_fs("vec_fs2");
      end
      blank_lz = vt[i].blz;
      wait_idx(vt[i].idx);
      check($sformatf("vec%0d_seg", i), seg_a, vt[i].seg);
      check($sformatf("vec%0d_dp", i), dp_a, vt[i].dpo);
    end

    // Load landing on the committing tick
    blank_lz = 1'b0;
    do_load(16'h1111, 4'h0, 1'b0);
    wait_fs("coin_fs0");
    wait_fs("coin_fs1");
    repeat (14) @(negedge clk);
    do_load(16'h2222, 4'h0, 1'b0);
    wait_fs("coin_fs2");
    check("coin_old", seg_a, 7'b0110000);
    wait_fs("coin_fs3");
    check("coin_new", seg_a, 7'b1101101);

    // Active-low segment pins
    do_load(16'h8888, 4'h0, 1'b0);
    wait_fs("inv_fs1");
    wait_fs("inv_fs2");
    check("inv_seg_b", seg_b, 7'h00);
    check("inv_dp_b", dp_b, 1'b1);
    check("inv_sel_ones", $countones(sel_b), 3);

    // Reset mid-scan discards pending data
    do_load(16'h5555, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_seg_a", seg_a, 7'h00);
    check("mid_rst_sel_a", sel_a, 4'hF);
    check("mid_rst_seg_b", seg_b, 7'h7F);
    check("mid_rst_idx", idx_a, 2'd0);
    rst_n = 1'b1;
    wait_fs("post_rst_fs");
    check("post_rst_d0", seg_a, 7'b1111110);

    // Random loads and blanking toggles
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        rv = 16'($urandom);
        for (int k = 0; k < 4; k++)
          if ($urandom_range(0, 1) == 1) rv[4*k +: 4] = 4'h0;
        value_in = rv;
        dp_in    = 4'($urandom);
        hex_mode = 1'($urandom);
      end
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
    end
    load = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
